// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S microphone receiver: controller states,
// default geometry constants and a small width helper.
package i2s_pkg;

    localparam int unsigned DEF_SAMPLE_WIDTH = 16;
    localparam int unsigned DEF_SLOT_WIDTH   = 32;
    localparam int unsigned DEF_CLK_DIV      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2s_pcm_rx_if.sv
// I2S serial pin bundle between the receiver (master, drives SCK/WS) and the
// microphone (slave, drives SD).
interface i2s_pcm_rx_if;

    logic sck;
    logic ws;
    logic sd;

    modport master (
        output sck,
        output ws,
        input  sd
    );

    modport slave (
        input  sck,
        input  ws,
        output sd
    );

endinterface

// File: rtl/i2s_clk_gen.sv
// SCK generator: divides clk by 2*CLK_DIV and flags the clk cycle in which
// SCK is about to rise or fall. clear holds the divider and SCK at zero.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          wrap;

    // Next divider count and SCK level; clear forces the parked state.
    always_comb begin
        wrap  = (cnt_q == CNT_MAX);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        sck_d = wrap ? ~sck_q : sck_q;
        if (clear) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end
    end

    // Divider and SCK registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    // Events are not gated by clear so a strobe due in the same cycle as a
    // disable still fires; a parked divider never reaches CNT_MAX anyway.
    assign sck  = sck_q;
    assign rise = wrap & ~sck_q;
    assign fall = wrap & sck_q;

endmodule

// File: rtl/i2s_pcm_rx.sv
// I2S microphone receiver: generates SCK/WS, deserialises the left slot
// MSB-first with the standard one-bit delay and strobes each sample out.
// Optional feature macro: I2S_SAMPLE_COUNT_EN adds sample_count_o.
module i2s_pcm_rx
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int unsigned SLOT_WIDTH   = DEF_SLOT_WIDTH,
    parameter int unsigned CLK_DIV      = DEF_CLK_DIV
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    output logic                    i2s_sck_o,
    output logic                    i2s_ws_o,
    input  logic                    i2s_sd_i,
    output logic [SAMPLE_WIDTH-1:0] pcm_o,
    output logic                    pcm_ready_o
`ifdef I2S_SAMPLE_COUNT_EN
    ,
    output logic [31:0]             sample_count_o
`endif
);

    localparam int unsigned FRAME = 2 * SLOT_WIDTH;
    localparam int unsigned BW    = cnt_width(FRAME);
    localparam logic [BW-1:0] B_LAST = BW'(FRAME - 1);
    localparam logic [BW-1:0] B_SLOT = BW'(SLOT_WIDTH);
    localparam logic [BW-1:0] B_MSB  = BW'(1);
    localparam logic [BW-1:0] B_LSB  = BW'(SAMPLE_WIDTH);

    state_e                  state_q, state_d;
    logic [BW-1:0]           b_q, b_d;
    logic                    ws_q, ws_d;
    logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d;
    logic [SAMPLE_WIDTH-1:0] pcm_q, pcm_d;
    logic                    ready_q, ready_d;
    logic [SAMPLE_WIDTH:0]   shift_in;
    logic                    gen_clear, gen_sck, gen_rise, gen_fall;
    logic                    strobe_due;

    // Serial pins grouped in one bundle; the module ports mirror it.
    i2s_pcm_rx_if pins ();

    assign pins.sck  = gen_sck;
    assign pins.ws   = ws_q;
    assign pins.sd   = i2s_sd_i;
    assign i2s_sck_o = pins.sck;
    assign i2s_ws_o  = pins.ws;

    // Divider is parked whenever the interface is not (or no longer) running.
    assign gen_clear = !enable_i || (state_q == IDLE);

    i2s_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (gen_clear),
        .sck   (gen_sck),
        .rise  (gen_rise),
        .fall  (gen_fall)
    );

    // Controller next state: one full SYNC frame before strobes are allowed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i) state_d = SYNC;
            SYNC:    if (gen_fall && (b_q == B_LAST)) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (!enable_i) state_d = IDLE;
    end

    // Frame position, word select, deserialiser and output strobe.
    always_comb begin
        b_d      = b_q;
        ws_d     = ws_q;
        shreg_d  = shreg_q;
        pcm_d    = pcm_q;
        ready_d  = 1'b0;
        shift_in = {shreg_q, pins.sd};

        // Bits 1..SAMPLE_WIDTH of the left slot carry the sample; b = 0 is
        // the one-bit delay after the WS transition.
        if (gen_rise && (b_q >= B_MSB) && (b_q <= B_LSB)) begin
            shreg_d = shift_in[SAMPLE_WIDTH-1:0];
        end

        if (gen_fall) begin
            b_d  = (b_q == B_LAST) ? '0 : b_q + 1'b1;
            ws_d = (b_d >= B_SLOT);
        end

        // Strobe uses the LSB being sampled right now, so it is not held off
        // by a simultaneous disable.
        strobe_due = (state_q == RUN) && gen_rise && (b_q == B_LSB);
        if (strobe_due) begin
            pcm_d   = shift_in[SAMPLE_WIDTH-1:0];
            ready_d = 1'b1;
        end

        if (gen_clear) begin
            b_d     = '0;
            ws_d    = 1'b0;
            shreg_d = '0;
        end
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            b_q     <= '0;
            ws_q    <= 1'b0;
            shreg_q <= '0;
            pcm_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            ws_q    <= ws_d;
            shreg_q <= shreg_d;
            pcm_q   <= pcm_d;
            ready_q <= ready_d;
        end
    end

    assign pcm_o       = pcm_q;
    assign pcm_ready_o = ready_q;

`ifdef I2S_SAMPLE_COUNT_EN
    logic [31:0] count_q;

    // Free-running count of emitted samples; holds while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (strobe_due) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign sample_count_o = count_q;
`endif

endmodule

// File: tb/tb_i2s_pcm_rx.sv
// Self-checking bench for i2s_pcm_rx with an I2S microphone model and a
// queue of expected samples.
module tb_i2s_pcm_rx;
    import i2s_pkg::*;

    localparam int unsigned SW   = DEF_SAMPLE_WIDTH;
    localparam int unsigned SLOT = DEF_SLOT_WIDTH;
    localparam int unsigned DIV  = DEF_CLK_DIV;
    localparam int unsigned FRAME_CYC = 4 * DIV * SLOT;
    // enable sampled on the first edge, one SYNC frame, then LSB rise + 1.
    localparam int unsigned FIRST_CYC = 1 + FRAME_CYC + 2 * DIV * SW + DIV;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [SW-1:0] pcm;
    logic          pcm_ready;
`ifdef I2S_SAMPLE_COUNT_EN
    logic [31:0]   sample_count;
`endif

    i2s_pcm_rx_if pins ();

    int unsigned   cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] left_word = '0;
    logic [SW-1:0] right_word = '0;
    logic [SW-1:0] last_pcm = '0;
    int unsigned   t_strobe = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_pcm_rx #(
        .SAMPLE_WIDTH (SW),
        .SLOT_WIDTH   (SLOT),
        .CLK_DIV      (DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable),
        .i2s_sck_o   (pins.sck),
        .i2s_ws_o    (pins.ws),
        .i2s_sd_i    (pins.sd),
        .pcm_o       (pcm),
        .pcm_ready_o (pcm_ready)
`ifdef I2S_SAMPLE_COUNT_EN
        ,
        .sample_count_o (sample_count)
`endif
    );

    // Microphone: new bit after every SCK fall; position restarts on WS change.
    initial begin
        int  pos;
        logic ws_prev;
        pos = 0;
        ws_prev = 1'b0;
        pins.sd = 1'b0;
        forever begin
            @(negedge pins.sck);
            #1;
            if (pins.ws !== ws_prev) pos = 0;
            else pos++;
            ws_prev = pins.ws;
            if (pos >= 1 && pos <= SW)
                pins.sd = pins.ws ? right_word[SW-pos] : left_word[SW-pos];
            else
                pins.sd = 1'($urandom);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_strobe(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pcm_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic pop_exp(output logic [SW-1:0] e);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 'x;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        repeat (2 * DIV + 2) @(negedge clk);
        n_cmp++; if (pins.sck !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b, expected 0", pins.sck); end
        n_cmp++; if (pins.ws !== 1'b0) begin n_bad++; $display("FAIL reset_ws: got %b, expected 0", pins.ws); end
        n_cmp++; if (pcm !== '0) begin n_bad++; $display("FAIL reset_pcm: got %h, expected 0", pcm); end
        n_cmp++; if (pcm_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b, expected 0", pcm_ready); end
        enable = 1'b0;
        rst_n = 1'b1;
        repeat (2 * DIV + 2) @(negedge clk);
        n_cmp++; if (pins.sck !== 1'b0) begin n_bad++; $display("FAIL idle_sck: got %b, expected 0", pins.sck); end
    endtask

    task automatic test_timing();
        logic [SW-1:0] words [4];
        logic [SW-1:0] e;
        int unsigned c0, first_rise, gap, prev;
        int rises;
        bit got;
        logic prev_sck;
        words[0] = 16'h8001; words[1] = 16'h8001; words[2] = 16'h4C2B; words[3] = 16'hA5C3;
        left_word = words[0];
        right_word = 16'h7FFF;
        exp_q.push_back(words[0]);
        @(negedge clk);
        enable = 1'b1;
        c0 = cyc;
        prev_sck = 1'b0;
        rises = 0;
        first_rise = 0;
        gap = 0;
        while (pcm_ready !== 1'b1 && cyc < c0 + FIRST_CYC + 50) begin
            @(negedge clk);
            if (pins.sck === 1'b1 && prev_sck === 1'b0) begin
                if (rises == 0) first_rise = cyc;
                if (rises == 1) gap = cyc - first_rise;
                rises++;
            end
            prev_sck = pins.sck;
        end
        n_cmp++; if (first_rise - c0 !== DIV + 1) begin n_bad++; $display("FAIL first_sck_rise: got %0d, expected %0d", first_rise - c0, DIV + 1); end
        n_cmp++; if (gap !== 2 * DIV) begin n_bad++; $display("FAIL sck_period: got %0d, expected %0d", gap, 2 * DIV); end
        n_cmp++; if (cyc - c0 !== FIRST_CYC) begin n_bad++; $display("FAIL first_strobe_latency: got %0d, expected %0d", cyc - c0, FIRST_CYC); end
        pop_exp(e);
        n_cmp++; if (pcm !== e) begin n_bad++; $display("FAIL pcm_frame0: got %h, expected %h", pcm, e); end
        last_pcm = e;
        prev = cyc;
        left_word = words[1];
        exp_q.push_back(words[1]);
        @(negedge clk);
        n_cmp++; if (pcm_ready !== 1'b0) begin n_bad++; $display("FAIL strobe_width: got %b, expected 0", pcm_ready); end
        // WS is high from b = SLOT; the strobe sits 4 cycles into b = SW.
        while (cyc < prev + 2 * DIV * (SLOT - SW) - 8) @(negedge clk);
        n_cmp++; if (pins.ws !== 1'b0) begin n_bad++; $display("FAIL ws_left: got %b, expected 0", pins.ws); end
        while (cyc < prev + 2 * DIV * (SLOT - SW) + 2) @(negedge clk);
        n_cmp++; if (pins.ws !== 1'b1) begin n_bad++; $display("FAIL ws_right: got %b, expected 1", pins.ws); end
        for (int k = 1; k < 4; k++) begin
            wait_strobe(FRAME_CYC + 20, got);
            n_cmp++; if (!got || cyc - prev !== FRAME_CYC) begin n_bad++; $display("FAIL strobe_period[%0d]: got %0d, expected %0d", k, cyc - prev, FRAME_CYC); end
            pop_exp(e);
            n_cmp++; if (pcm !== e) begin n_bad++; $display("FAIL pcm_frame%0d: got %h, expected %h", k, pcm, e); end
            last_pcm = e;
            prev = cyc;
            if (k < 3) begin
                left_word = words[k + 1];
                exp_q.push_back(words[k + 1]);
            end
        end
        t_strobe = prev;
    endtask

    task automatic test_enable_drop();
        logic [SW-1:0] e;
        int unsigned c0;
        bit got;
        left_word = 16'h0F0F;
        // Mid b = 8 of the next left slot.
        while (cyc < t_strobe + 448) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (pins.sck !== 1'b0) begin n_bad++; $display("FAIL drop_sck: got %b, expected 0", pins.sck); end
        n_cmp++; if (pins.ws !== 1'b0) begin n_bad++; $display("FAIL drop_ws: got %b, expected 0", pins.ws); end
        n_cmp++; if (pcm !== last_pcm) begin n_bad++; $display("FAIL drop_pcm_hold: got %h, expected %h", pcm, last_pcm); end
        wait_strobe(FRAME_CYC + 100, got);
        n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL drop_no_strobe: got %b, expected 0", got); end
        exp_q.push_back(16'h0F0F);
        enable = 1'b1;
        c0 = cyc;
        wait_strobe(FIRST_CYC + 50, got);
        n_cmp++; if (!got || cyc - c0 !== FIRST_CYC) begin n_bad++; $display("FAIL reenable_latency: got %0d, expected %0d", cyc - c0, FIRST_CYC); end
        pop_exp(e);
        n_cmp++; if (pcm !== e) begin n_bad++; $display("FAIL reenable_pcm: got %h, expected %h", pcm, e); end
        last_pcm = e;
        t_strobe = cyc;
    endtask

    task automatic test_reset_mid_run();
        logic [SW-1:0] e;
        int unsigned c0;
        bit got;
        left_word = 16'h3C5A;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (pins.sck !== 1'b0) begin n_bad++; $display("FAIL rst_run_sck: got %b, expected 0", pins.sck); end
        n_cmp++; if (pins.ws !== 1'b0) begin n_bad++; $display("FAIL rst_run_ws: got %b, expected 0", pins.ws); end
        n_cmp++; if (pcm !== '0) begin n_bad++; $display("FAIL rst_run_pcm: got %h, expected 0", pcm); end
        n_cmp++; if (pcm_ready !== 1'b0) begin n_bad++; $display("FAIL rst_run_ready: got %b, expected 0", pcm_ready); end
        rst_n = 1'b1;
        c0 = cyc;
        exp_q.push_back(16'h3C5A);
        wait_strobe(FIRST_CYC + 50, got);
        n_cmp++; if (!got || cyc - c0 !== FIRST_CYC) begin n_bad++; $display("FAIL rst_restart_latency: got %0d, expected %0d", cyc - c0, FIRST_CYC); end
        pop_exp(e);
        n_cmp++; if (pcm !== e) begin n_bad++; $display("FAIL rst_restart_pcm: got %h, expected %h", pcm, e); end
        last_pcm = e;
        t_strobe = cyc;
    endtask

    task automatic test_enable_in_strobe();
        logic [SW-1:0] e;
        bit got;
        left_word = 16'hC001;
        exp_q.push_back(16'hC001);
        // Drop enable during the LSB rise cycle so it lands with the due strobe.
        while (cyc < t_strobe + FRAME_CYC - 1) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (pcm_ready !== 1'b1) begin n_bad++; $display("FAIL late_drop_strobe: got %b, expected 1", pcm_ready); end
        pop_exp(e);
        n_cmp++; if (pcm !== e) begin n_bad++; $display("FAIL late_drop_pcm: got %h, expected %h", pcm, e); end
        n_cmp++; if (pins.sck !== 1'b0) begin n_bad++; $display("FAIL late_drop_sck: got %b, expected 0", pins.sck); end
        @(negedge clk);
        n_cmp++; if (pcm_ready !== 1'b0) begin n_bad++; $display("FAIL late_drop_single: got %b, expected 0", pcm_ready); end
        wait_strobe(FRAME_CYC + 200, got);
        n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL late_drop_idle: got %b, expected 0", got); end
        n_cmp++; if (pcm !== e) begin n_bad++; $display("FAIL late_drop_hold: got %h, expected %h", pcm, e); end
    endtask

`ifdef I2S_SAMPLE_COUNT_EN
    task automatic test_sample_count();
        logic [SW-1:0] e;
        bit got;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (sample_count !== 32'd0) begin n_bad++; $display("FAIL count_reset: got %0d, expected 0", sample_count); end
        left_word = 16'h5555;
        right_word = 16'hAAAA;
        for (int k = 0; k < 10; k++) exp_q.push_back(16'h5555);
        enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_strobe(FIRST_CYC + 50, got);
            pop_exp(e);
            n_cmp++; if (!got || pcm !== e) begin n_bad++; $display("FAIL count_pcm[%0d]: got %h, expected %h", k, pcm, e); end
        end
        n_cmp++; if (sample_count !== 32'd10) begin n_bad++; $display("FAIL count_ten: got %0d, expected 10", sample_count); end
        enable = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (sample_count !== 32'd10) begin n_bad++; $display("FAIL count_hold: got %0d, expected 10", sample_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_timing();
        test_enable_drop();
        test_reset_mid_run();
        test_enable_in_strobe();
`ifdef I2S_SAMPLE_COUNT_EN
        test_sample_count();
`endif
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
